mcd_mem_arb: RTL and testbench

MCD_MEM_ARB -- requirements
Module: mcd_mem_arb

---
 rtl/mcd_mem_arb_if.sv | 31 +++
 rtl/mcd_mem_arb.sv | 121 ++++++++++++
 tb/tb_mcd_mem_arb.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcd_mem_arb_if.sv
// Requester-side and memory-side signal bundle of the MCD memory arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mcd_mem_arb_if #(
    parameter int AW = 23
);
    logic [3:0]      rq_req;
    logic [3:0]      rq_we;
    logic [7:0]      rq_be;
    logic [4*AW-1:0] rq_addr;
    logic [63:0]     rq_wdat;
    logic [3:0]      rq_ack;
    logic [15:0]     rq_rdat;

    logic            mem_req;
    logic            mem_we;
    logic [1:0]      mem_be;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_wdat;
    logic            mem_rdy;
    logic [15:0]     mem_rdat;

    modport master (
        input  rq_req, rq_we, rq_be, rq_addr, rq_wdat, mem_rdy, mem_rdat,
        output rq_ack, rq_rdat, mem_req, mem_we, mem_be, mem_addr, mem_wdat
    );

    modport slave (
        output rq_req, rq_we, rq_be, rq_addr, rq_wdat, mem_rdy, mem_rdat,
        input  rq_ack, rq_rdat, mem_req, mem_we, mem_be, mem_addr, mem_wdat
    );
endinterface

// File: rtl/mcd_mem_arb.sv
// Four-requester 16-bit memory arbiter: fixed priority for requester 0,
// round-robin among 1..3, one access at a time with a per-access watchdog.
module mcd_mem_arb #(
    parameter int AW  = 23,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          map_rst,
    mcd_mem_arb_if.master bus,
    output logic          err_tmo
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    pick, win, rr_ptr;
    logic [1:0]    c1, c2, c3;
    logic [15:0]   wdog;
    logic          tmo_hit;
    logic          we_q;
    logic [1:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdat_q, rdat_q;

    logic [AW-1:0] addr_a [4];
    logic [15:0]   wdat_a [4];
    logic [1:0]    be_a   [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            addr_a[n] = bus.rq_addr[n*AW +: AW];
            wdat_a[n] = bus.rq_wdat[n*16 +: 16];
            be_a[n]   = bus.rq_be[n*2 +: 2];
        end
    end

    assign tmo_hit = (wdog == 16'(TMO));

    // Requester 0 always wins; otherwise search 1..3 starting just after rr_ptr.
    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        pick = 2'd0;
        c1   = 2'd1;
        c2   = 2'd2;
        c3   = 2'd3;
        case (rr_ptr)
            2'd1:    {c1, c2, c3} = {2'd2, 2'd3, 2'd1};
            2'd2:    {c1, c2, c3} = {2'd3, 2'd1, 2'd2};
            default: {c1, c2, c3} = {2'd1, 2'd2, 2'd3};
        endcase
        if (bus.rq_req[0])       pick = 2'd0;
        else if (bus.rq_req[c1]) pick = c1;
        else if (bus.rq_req[c2]) pick = c2;
        else                     pick = c3;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (map_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.rq_req) state_nxt = BUSY;
            BUSY:    if (bus.mem_rdy || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, watchdog and read-data latch; mem_rdy outside BUSY is ignored.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            win     <= 2'd0;
            rr_ptr  <= 2'd3;
            wdog    <= 16'd0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdat_q  <= 16'd0;
            rdat_q  <= 16'd0;
            err_tmo <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.rq_req) begin
                        win    <= pick;
                        we_q   <= bus.rq_we[pick];
                        be_q   <= be_a[pick];
                        addr_q <= addr_a[pick];
                        wdat_q <= wdat_a[pick];
                        wdog   <= 16'd0;
                        if (pick != 2'd0) rr_ptr <= pick;
                    end
                end
                BUSY: begin
                    if (bus.mem_rdy) begin
                        rdat_q <= bus.mem_rdat;
                    end else if (tmo_hit) begin
                        rdat_q  <= 16'hFFFF;
                        err_tmo <= 1'b1;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req  = (state == BUSY);
    assign bus.mem_we   = we_q;
    assign bus.mem_be   = be_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wdat = wdat_q;
    assign bus.rq_rdat  = rdat_q;
    assign bus.rq_ack   = (state == DONE) ? (4'b0001 << win) : 4'b0000;

endmodule

// File: tb/tb_mcd_mem_arb.sv
// Self-checking bench for mcd_mem_arb: vector table, hand-written corner
// sequences, and random traffic against a rotating-queue arbitration model.
module tb_mcd_mem_arb;

    localparam int AW  = 23;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic map_rst;
    logic err_tmo;

    mcd_mem_arb_if #(.AW(AW)) bus ();

    mcd_mem_arb #(.AW(AW), .TMO(TMO)) dut (
        .clk     (clk),
        .map_rst (map_rst),
        .bus     (bus),
        .err_tmo (err_tmo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: round-robin order as a queue of requesters 1..3,
    // rotated so the last granted one sits at the back.
    int   rr_q[$];
    logic err_m;

    typedef struct {
        logic [3:0]    req;
        logic [3:0]    we;
        logic [7:0]    be;
        logic [AW-1:0] abase;
        logic [15:0]   wbase;
        int            dly;
        logic [15:0]   mrdat;
        int            win;
        logic [15:0]   rdat;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
        if (r[0]) return 0;
        foreach (rr_q[i]) if (r[2'(rr_q[i])]) return rr_q[i];
        return -1;
    endfunction

    task automatic model_grant(input int n);
        if (n != 0) begin
            while (rr_q[$] != n) rr_q.push_back(rr_q.pop_front());
        end
    endtask

    task automatic do_reset();
        map_rst      = 1'b1;
        bus.rq_req   = 4'b0;
        bus.mem_rdy  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        map_rst = 1'b0;
        rr_q    = {1, 2, 3};
        err_m   = 1'b0;
    endtask

    // Starts at a negedge in IDLE with rq_req already driven; ends at the
    // following IDLE negedge. dly = BUSY cycles before mem_rdy (>TMO: never).
    task automatic access(input int want_w, input int dly, input logic [15:0] mrdat,
                          input logic [15:0] want_rdat, input logic want_err,
                          input logic drop, input logic scramble);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [1:0]    e_be;
        logic [15:0]   e_wdat;
        logic [3:0]    saved_req;
        logic          held;
        int            last;
        e_addr    = bus.rq_addr[want_w*AW +: AW];
        e_we      = bus.rq_we[want_w];
        e_be      = bus.rq_be[want_w*2 +: 2];
        e_wdat    = bus.rq_wdat[want_w*16 +: 16];
        saved_req = bus.rq_req;
        last      = (dly <= TMO) ? dly : TMO;
        held      = 1'b1;
        @(negedge clk);
        check("mem_req_rise", bus.mem_req, 1);
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_we", bus.mem_we, e_we);
        check("mem_be", bus.mem_be, e_be);
        check("mem_wdat", bus.mem_wdat, e_wdat);
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.rq_ack !== 4'b0 || bus.mem_addr !== e_addr ||
                bus.mem_we !== e_we || bus.mem_be !== e_be || bus.mem_wdat !== e_wdat)
                held = 1'b0;
            if (c == dly) begin
                bus.mem_rdy  = 1'b1;
                bus.mem_rdat = mrdat;
            end
            if (scramble) begin
                bus.rq_req  = 4'($urandom);
                bus.rq_we   = 4'($urandom);
                bus.rq_be   = 8'($urandom);
                bus.rq_addr = {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)};
                bus.rq_wdat = {$urandom, $urandom};
            end
        end
        check("busy_hold", held, 1);
        @(negedge clk);
        bus.mem_rdy  = 1'b0;
        bus.mem_rdat = 16'($urandom);
        bus.rq_req   = saved_req;
        check("rq_ack", bus.rq_ack, 4'b0001 << want_w);
        if (!e_we) check("rq_rdat", bus.rq_rdat, want_rdat);
        check("err_tmo", err_tmo, want_err);
        check("mem_req_fall", bus.mem_req, 0);
        if (drop) bus.rq_req[want_w] = 1'b0;
        model_grant(want_w);
        @(negedge clk);
        check("ack_one_cycle", bus.rq_ack, 0);
    endtask

    task automatic idle_rdy();
        bus.mem_rdy  = 1'b1;
        bus.mem_rdat = 16'h7777;
        @(negedge clk);
        bus.mem_rdy = 1'b0;
        check("idle_rdy_req", bus.mem_req, 0);
        @(negedge clk);
        check("idle_rdy_ack", bus.rq_ack, 0);
    endtask

    task automatic run_random(input int n);
        logic [3:0]  fresh;
        logic [15:0] md;
        int          w, dly;
        for (int t = 0; t < n; t++) begin
            fresh = 4'($urandom_range(0, 15)) & ~bus.rq_req;
            for (int r = 0; r < 4; r++) begin
                if (fresh[r]) begin
                    bus.rq_we[r]             = 1'($urandom_range(0, 1));
                    bus.rq_be[r*2 +: 2]      = 2'($urandom_range(0, 3));
                    bus.rq_addr[r*AW +: AW]  = AW'($urandom);
                    bus.rq_wdat[r*16 +: 16]  = 16'($urandom);
                end
            end
            bus.rq_req = bus.rq_req | fresh;
            if (bus.rq_req == 4'b0) begin
                idle_rdy();
            end else begin
                w   = model_pick(bus.rq_req);
                dly = $urandom_range(0, TMO + 2);
                md  = 16'($urandom);
                if (dly > TMO) err_m = 1'b1;
                access(w, dly, md, (dly <= TMO) ? md : 16'hFFFF, err_m, 1'b1, 1'b1);
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not finish, got hang want finish");
        $fatal(1);
    end

    initial begin
        bus.rq_req  = 4'b0;
        bus.rq_we   = 4'b0;
        bus.rq_be   = 8'b0;
        bus.rq_addr = '0;
        bus.rq_wdat = '0;
        bus.mem_rdy = 1'b0;
        bus.mem_rdat = 16'h0;

        //            req      we       be     abase       wbase     dly      mrdat    win rdat
        tbl[0] = '{4'b1111, 4'b0000, 8'hE4, 23'h000100, 16'hA000, 0,       16'h0001, 0, 16'h0001};
        tbl[1] = '{4'b1110, 4'b0000, 8'hE4, 23'h000200, 16'hA100, 1,       16'h0002, 1, 16'h0002};
        tbl[2] = '{4'b1100, 4'b0000, 8'hE4, 23'h000300, 16'hA200, 2,       16'h0003, 2, 16'h0003};
        tbl[3] = '{4'b1000, 4'b0000, 8'hE4, 23'h000400, 16'hA300, 3,       16'h0004, 3, 16'h0004};
        tbl[4] = '{4'b0100, 4'b0000, 8'h1B, 23'h001232, 16'hB000, 5,       16'hBEEF, 2, 16'hBEEF};
        tbl[5] = '{4'b0010, 4'b0010, 8'hD2, 23'h7FFF00, 16'hC000, 0,       16'h5555, 1, 16'h0000};
        tbl[6] = '{4'b1000, 4'b0000, 8'h9C, 23'h012300, 16'hD000, TMO - 1, 16'h5A5A, 3, 16'h5A5A};
        tbl[7] = '{4'b0001, 4'b0000, 8'h27, 23'h045600, 16'hE000, TMO,     16'hC3C3, 0, 16'hC3C3};

        // Reset state
        do_reset();
        check("rst_ack", bus.rq_ack, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdat", bus.mem_wdat, 0);
        check("rst_rq_rdat", bus.rq_rdat, 0);
        check("rst_err_tmo", err_tmo, 0);

        // Vector table: contention order, single read, write with be=00, watchdog boundary
        for (int i = 0; i < 8; i++) begin
            bus.rq_req = tbl[i].req;
            bus.rq_we  = tbl[i].we;
            bus.rq_be  = tbl[i].be;
            for (int n = 0; n < 4; n++) begin
                bus.rq_addr[n*AW +: AW] = tbl[i].abase + AW'(n);
                bus.rq_wdat[n*16 +: 16] = tbl[i].wbase + 16'(n);
            end
            access(tbl[i].win, tbl[i].dly, tbl[i].mrdat, tbl[i].rdat, 1'b0, 1'b1, 1'b0);
        end

        // Fairness: 1..3 held continuously, req0 raised mid-sequence
        bus.rq_we  = 4'b0;
        bus.rq_req = 4'b1110;
        access(1, 0, 16'h1001, 16'h1001, 1'b0, 1'b0, 1'b0);
        access(2, 1, 16'h1002, 16'h1002, 1'b0, 1'b0, 1'b0);
        access(3, 0, 16'h1003, 16'h1003, 1'b0, 1'b0, 1'b0);
        access(1, 2, 16'h1004, 16'h1004, 1'b0, 1'b0, 1'b0);
        bus.rq_req[0] = 1'b1;
        access(0, 0, 16'h1000, 16'h1000, 1'b0, 1'b1, 1'b0);
        access(2, 0, 16'h1005, 16'h1005, 1'b0, 1'b0, 1'b0);
        access(3, 1, 16'h1006, 16'h1006, 1'b0, 1'b0, 1'b0);
        access(1, 0, 16'h1007, 16'h1007, 1'b0, 1'b1, 1'b0);
        bus.rq_req = 4'b0;
        @(negedge clk);

        // Timeout: mem_rdy never arrives; err_tmo then stays set
        bus.rq_req = 4'b0100;
        access(2, 1000, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        bus.rq_req = 4'b0010;
        access(1, 0, 16'h2468, 16'h2468, 1'b1, 1'b1, 1'b0);

        // Reset two cycles into BUSY, then a late mem_rdy
        bus.rq_req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check("rstbusy_mem_req", bus.mem_req, 1);
        map_rst    = 1'b1;
        bus.rq_req = 4'b0;
        @(negedge clk);
        map_rst      = 1'b0;
        rr_q         = {1, 2, 3};
        err_m        = 1'b0;
        bus.mem_rdy  = 1'b1;
        bus.mem_rdat = 16'h1357;
        check("rstbusy_req_low", bus.mem_req, 0);
        check("rstbusy_err_clr", err_tmo, 0);
        @(negedge clk);
        bus.mem_rdy = 1'b0;
        check("rstbusy_no_ack", bus.rq_ack, 0);
        check("rstbusy_rdat", bus.rq_rdat, 0);
        @(negedge clk);
        check("rstbusy_no_ack2", bus.rq_ack, 0);
        idle_rdy();

        // Pointer back at 3 after reset: requester 1 wins first
        bus.rq_req = 4'b1110;
        access(1, 3, 16'h3141, 16'h3141, 1'b0, 1'b1, 1'b0);
        bus.rq_req = 4'b0;
        @(negedge clk);

        // Random traffic against the model
        do_reset();
        run_random(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
